// File: rtl/rv32v_memory_stage.sv
// Vector memory stage: latches one two-lane vector op, performs the lane
// accesses to data memory one after the other, then presents the result
// as a single-cycle writeback pulse.

package rv32v_types_pkg;
    typedef logic [4:0] offset_t;
endpackage

module rv32v_memory_stage
    import rv32v_types_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    output logic        mem_ready,
    input  logic        load,
    input  logic        store,
    input  logic        wen0,
    input  logic        wen1,
    input  logic [31:0] aluresult0,
    input  logic [31:0] aluresult1,
    input  logic [31:0] storedata0,
    input  logic [31:0] storedata1,
    input  offset_t     woffset0,
    input  offset_t     woffset1,
    input  logic        config_type,
    input  logic [31:0] vl,
    input  logic [31:0] vtype,
    output logic        dmem_ren,
    output logic        dmem_wen,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_busy,
    input  logic        flush,
    output logic        wb_valid,
    output logic [31:0] wb_wdat0,
    output logic [31:0] wb_wdat1,
    output logic        wb_wen0,
    output logic        wb_wen1,
    output offset_t     wb_woffset0,
    output offset_t     wb_woffset1,
    output logic        wb_config_type,
    output logic [31:0] wb_vl,
    output logic [31:0] wb_vtype,
    output logic        wb_misaligned,
    output logic        wb_timeout
);

    typedef enum logic [1:0] {IDLE, LANE0, LANE1, DONE} state_t;

    localparam int             CW        = $clog2(WAIT_LIMIT + 1);
    localparam logic [CW-1:0]  LAST_WAIT = CW'(WAIT_LIMIT - 1);

    state_t        state_q, state_d;
    logic          op_load_q, op_store_q;
    logic          wen0_q, wen1_q;
    logic [31:0]   addr0_q, addr1_q, sdata0_q, sdata1_q;
    logic [31:0]   wdat0_q, wdat1_q;
    offset_t       woff0_q, woff1_q;
    logic          cfg_q;
    logic [31:0]   vl_q, vtype_q;
    logic          misal_q, tmo_q;
    logic [CW-1:0] wait_q;

    // Current lane view: which address is on the bus and how the access ends.
    logic        in_lane, lane_misal, lane_tmo, lane_done;
    logic [31:0] lane_addr, lane_sdata, lane_result;

    assign in_lane     = (state_q == LANE0) || (state_q == LANE1);
    assign lane_addr   = (state_q == LANE1) ? addr1_q  : addr0_q;
    assign lane_sdata  = (state_q == LANE1) ? sdata1_q : sdata0_q;
    assign lane_misal  = |lane_addr[1:0];
    assign lane_tmo    = in_lane && !lane_misal && dmem_busy && (wait_q == LAST_WAIT);
    assign lane_done   = in_lane && (lane_misal || !dmem_busy || lane_tmo);
    // Stores keep the lane address as their result; failed lanes return zero.
    assign lane_result = (lane_misal || lane_tmo) ? 32'h0 :
                         (op_load_q ? dmem_rdata : lane_addr);

    // State register; reset and flush both abandon whatever is in flight.
    always_ff @(posedge CLK) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update together from pre-edge values, independent of block order.
        state_q <= state_d;
    end

    // Next-state and strobe/handshake decode.
    always_comb begin
        // NOTE: every output gets a default first, so no path can leave one
        // unassigned and infer a latch.
        state_d    = state_q;
        mem_ready  = 1'b0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        wb_valid   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_ready = 1'b1;
                if (ex_valid) begin
                    if ((load || store) && wen0)      state_d = LANE0;
                    else if ((load || store) && wen1) state_d = LANE1;
                    else                              state_d = DONE;
                end
            end
            LANE0, LANE1: begin
                dmem_addr  = lane_addr;
                dmem_wdata = lane_sdata;
                if (!lane_misal) begin
                    dmem_ren = op_load_q;
                    dmem_wen = op_store_q;
                end
                if (lane_done)
                    state_d = (state_q == LANE0 && wen1_q) ? LANE1 : DONE;
            end
            DONE: begin
                wb_valid = !flush;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (RST || flush) state_d = IDLE;
        // Reset forces the idle view on the outputs even before the first edge.
        if (RST) begin
            mem_ready  = 1'b1;
            dmem_ren   = 1'b0;
            dmem_wen   = 1'b0;
            dmem_addr  = 32'h0;
            dmem_wdata = 32'h0;
            wb_valid   = 1'b0;
        end
    end

    // Op latch, per-lane result capture, wait counter and sticky error flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_load_q  <= 1'b0;
            op_store_q <= 1'b0;
            wen0_q     <= 1'b0;
            wen1_q     <= 1'b0;
            addr0_q    <= '0;
            addr1_q    <= '0;
            sdata0_q   <= '0;
            sdata1_q   <= '0;
            wdat0_q    <= '0;
            wdat1_q    <= '0;
            woff0_q    <= '0;
            woff1_q    <= '0;
            cfg_q      <= 1'b0;
            vl_q       <= '0;
            vtype_q    <= '0;
            misal_q    <= 1'b0;
            tmo_q      <= 1'b0;
            wait_q     <= '0;
        end else if (flush) begin
            misal_q <= 1'b0;
            tmo_q   <= 1'b0;
            wait_q  <= '0;
        end else if (state_q == IDLE && ex_valid) begin
            op_load_q  <= load;
            op_store_q <= store;
            wen0_q     <= wen0;
            wen1_q     <= wen1;
            addr0_q    <= aluresult0;
            addr1_q    <= aluresult1;
            sdata0_q   <= storedata0;
            sdata1_q   <= storedata1;
            wdat0_q    <= wen0 ? aluresult0 : 32'h0;
            wdat1_q    <= wen1 ? aluresult1 : 32'h0;
            woff0_q    <= woffset0;
            woff1_q    <= woffset1;
            cfg_q      <= config_type;
            vl_q       <= vl;
            vtype_q    <= vtype;
            misal_q    <= 1'b0;
            tmo_q      <= 1'b0;
            wait_q     <= '0;
        end else if (in_lane) begin
            if (lane_done) begin
                wait_q <= '0;
                if (lane_misal) misal_q <= 1'b1;
                if (lane_tmo)   tmo_q   <= 1'b1;
                if (state_q == LANE1) wdat1_q <= lane_result;
                else                  wdat0_q <= lane_result;
            end else begin
                wait_q <= wait_q + CW'(1);
            end
        end
    end

    assign wb_wdat0       = RST ? 32'h0 : wdat0_q;
    assign wb_wdat1       = RST ? 32'h0 : wdat1_q;
    assign wb_wen0        = !RST && wen0_q;
    assign wb_wen1        = !RST && wen1_q;
    assign wb_woffset0    = RST ? offset_t'(0) : woff0_q;
    assign wb_woffset1    = RST ? offset_t'(0) : woff1_q;
    assign wb_config_type = !RST && cfg_q;
    assign wb_vl          = RST ? 32'h0 : vl_q;
    assign wb_vtype       = RST ? 32'h0 : vtype_q;
    assign wb_misaligned  = !RST && misal_q;
    assign wb_timeout     = !RST && tmo_q;

endmodule

// File: doc/rv32v_memory_stage.md
RV32V_MEMORY_STAGE -- requirements
Module: rv32v_memory_stage

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 16: the maximum number of consecutive dmem_busy cycles tolerated on a single lane access.
REQ-002 SHALL have one clock and one reset: reset is synchronous and active-high; ports are named CLK and RST as elsewhere in the codebase.
REQ-003 CLK  in  1  clock; all state updates on its rising edge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 ex_valid  in  1  execute stage presents a valid vector op this cycle.
REQ-006 mem_ready  out  1  stage can accept an op; high only in IDLE.
REQ-007 load, store  in  1 each  op is a vector load or store (mutually exclusive).
REQ-008 wen0, wen1  in  1 each  lane 0/1 active mask, also its writeback enable.
REQ-009 aluresult0, aluresult1  in  32 each  lane address for mem ops, otherwise lane result.
REQ-010 storedata0, storedata1  in  32 each  lane store data.
REQ-011 woffset0, woffset1  in  offset_t (rv32v_types_pkg) each  lane element offset.
REQ-012 config_type  in  1;  vl, vtype  in  32 each  configuration sideband.
REQ-013 dmem_ren, dmem_wen  out  1 each  data memory read/write strobe.
REQ-014 dmem_addr  out  32;  dmem_wdata  out  32;  dmem_rdata  in  32.
REQ-015 dmem_busy  in  1  memory not done; access completes in the first strobed cycle with dmem_busy=0.
REQ-016 flush  in  1  abort the in-flight op.
REQ-017 wb_valid  out  1  one-cycle writeback pulse.
REQ-018 wb_wdat0, wb_wdat1  out  32;  wb_wen0, wb_wen1  out  1;  wb_woffset0, wb_woffset1  out  offset_t.
REQ-019 wb_config_type  out  1;  wb_vl, wb_vtype  out  32.
REQ-020 wb_misaligned  out  1;  wb_timeout  out  1  (error flags, valid with wb_valid).

Function
REQ-021 FSM states SHALL be IDLE, LANE0, LANE1, DONE.
REQ-022 In IDLE with ex_valid=1, all inputs SHALL be latched. Next state: LANE0 if (load|store)&wen0; else LANE1 if (load|store)&wen1; else DONE.
REQ-023 Ops with neither load nor store SHALL go IDLE->DONE and forward aluresultN as wb_wdatN.
REQ-024 In LANEk, the stage SHALL drive dmem_addr=latched aluresultk and dmem_wdata=storedatak, and SHALL assert dmem_ren (load) or dmem_wen (store), holding all of them stable until completion.
REQ-025 On completion of a load, dmem_rdata SHALL be captured into wdatk. Store lanes SHALL keep wdatk=aluresultk.
REQ-026 LANE0 completion SHALL go to LANE1 if wen1, else DONE; LANE1 completion SHALL go to DONE.
REQ-027 A lane address with [1:0]!=0 SHALL NOT strobe memory; it completes immediately with wdatk=0 and sets the sticky misaligned flag.
REQ-028 A per-lane wait counter SHALL increment each busy cycle; at WAIT_LIMIT it forces completion with wdatk=0, sets the sticky timeout flag and deasserts the strobes.
REQ-029 DONE SHALL assert wb_valid for exactly one cycle with the latched/sideband values, then return to IDLE. Sticky flags SHALL clear on the next accept.
REQ-030 Zero-wait latency: accept at cycle t; a non-mem op gives wb_valid at t+1; a two-lane mem op gives wb_valid at t+3; a one-lane mem op gives wb_valid at t+2.
REQ-031 flush in any state SHALL force IDLE next cycle with no wb_valid, strobes low next cycle, and flags cleared. flush beats ex_valid in IDLE, so no accept occurs.
REQ-032 Inactive lanes (wenk=0) SHALL output wb_wenk=0 and wb_wdatk=0.

Reset
REQ-033 While RST=1, the stage SHALL be in IDLE, and all outputs and registers SHALL be 0 except mem_ready, which SHALL be 1. RST SHALL dominate flush and ex_valid.
REQ-034 RST asserted during LANEk SHALL drop the strobes on the next edge and discard the op.

Verification
REQ-035 ALU op, aluresult0=0x11, aluresult1=0x22, wen=11 -> wb_valid at t+1, wdat0=0x11, wdat1=0x22.
REQ-036 Load, addr0=0x100, addr1=0x104, rdata 0xA/0xB, busy=0 -> ren at t+1 (0x100) and t+2 (0x104); wb_valid at t+3 with 0xA/0xB.
REQ-037 Store, wen=01, busy high for 3 cycles -> exactly one dmem_wen lane held 4 cycles; wb_valid at t+5; mem_ready=0 throughout.
REQ-038 Load, addr0=0x102 -> no ren for lane0, wb_misaligned=1, wdat0=0.
REQ-039 Busy stuck with WAIT_LIMIT=16 -> wb_timeout=1 after 16 busy cycles on that lane.
REQ-040 flush during LANE1, and RST during LANE0 -> IDLE next cycle, no wb_valid, strobes 0, mem_ready=1.
